// File: rtl/dmc_descramble_demux.sv
// Preamble hunt/confirm, payload descramble and MSB-first demux for the DMC edge-decoder bit stream.
// Optional feature macro: DMC_DESCRAMBLE_EN (payload XOR with LFSR keystream); undefined = raw payload.
module dmc_descramble_demux #(
  parameter int         WORD_W      = 8,
  parameter int         FRAME_WORDS = 4,
  parameter logic [7:0] PREAMBLE    = 8'hAC,
  parameter int         TIMEOUT_CYC = 255
`ifdef DMC_DESCRAMBLE_EN
  ,
  parameter logic [6:0] LFSR_SEED   = 7'h7F
`endif
) (
  input  logic              clk_i,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              dec_bit,
  input  logic              dec_bit_vld,
  input  logic              dec_data_vld,
  output logic [WORD_W-1:0] rx_word,
  output logic              rx_word_vld,
  output logic              frame_done,
  output logic              frame_err,
  output logic              preamble_double_check,
  output logic              tdc_sum_vld_for_ten,
  output logic              tdc_sum_vld_for_fif,
  output logic [2:0]        state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_HUNT    = 3'd1,
    S_PRE2    = 3'd2,
    S_PAYLOAD = 3'd3,
    S_DONE    = 3'd4
  } state_e;

  localparam int BC_W = (WORD_W > 8) ? $clog2(WORD_W) : 3;
  localparam int WC_W = $clog2(FRAME_WORDS + 1);
  localparam logic [BC_W-1:0] LAST_BIT  = BC_W'(WORD_W - 1);
  localparam logic [WC_W-1:0] LAST_WORD = WC_W'(FRAME_WORDS - 1);
  localparam logic [7:0]      TMO_LIMIT = 8'(TIMEOUT_CYC - 1);

  state_e            state_q, state_d;
  logic [7:0]        sh_q, sh_d, sh_shift;
  logic [BC_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [WC_W-1:0]   word_cnt_q, word_cnt_d;
  logic [7:0]        tmo_q, tmo_d;
  logic [WORD_W-1:0] word_q, word_d, next_word;
  logic [WORD_W-1:0] rx_word_q, rx_word_d;
  logic              rx_word_vld_q, rx_word_vld_d;
  logic              frame_done_q, frame_done_d;
  logic              frame_err_q, frame_err_d;
  logic              pdc_q, pdc_d;
  logic              active, timeout, enter_payload, pay_strobe, ks;

  assign pay_strobe = enable && dec_data_vld && dec_bit_vld && (state_q == S_PAYLOAD);

`ifdef DMC_DESCRAMBLE_EN
  logic [6:0] lfsr_q, lfsr_d;

  assign ks = lfsr_q[6] ^ lfsr_q[5];

  always_comb begin
    lfsr_d = lfsr_q;
    if (enter_payload)   lfsr_d = LFSR_SEED;
    else if (pay_strobe) lfsr_d = {lfsr_q[5:0], ks};
  end

  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) lfsr_q <= LFSR_SEED;
    else          lfsr_q <= lfsr_d;
  end
`else
  assign ks = 1'b0;
`endif

  // NOTE: every always_comb output gets a default first, so no path can leave a latch behind.
  always_comb begin
    state_d       = state_q;
    sh_d          = sh_q;
    bit_cnt_d     = bit_cnt_q;
    word_cnt_d    = word_cnt_q;
    tmo_d         = tmo_q;
    word_d        = word_q;
    rx_word_d     = rx_word_q;
    rx_word_vld_d = 1'b0;
    frame_done_d  = 1'b0;
    frame_err_d   = 1'b0;
    enter_payload = 1'b0;
    sh_shift      = {sh_q[6:0], dec_bit};
    next_word     = {word_q[WORD_W-2:0], dec_bit ^ ks};
    active        = (state_q == S_HUNT) || (state_q == S_PRE2) || (state_q == S_PAYLOAD);
    timeout       = active && !dec_bit_vld && (tmo_q >= TMO_LIMIT);

    // Saturating gap counter; any strobe clears it, so a strobe beats a same-cycle timeout.
    if (active) tmo_d = dec_bit_vld ? 8'd0 : ((tmo_q == 8'hFF) ? 8'hFF : tmo_q + 8'd1);

    if (!enable) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (dec_data_vld) begin
          state_d = S_HUNT;
          sh_d    = '0;
        end
        S_HUNT: begin
          if (!dec_data_vld) state_d = S_IDLE;
          else if (timeout) begin
            state_d     = S_IDLE;
            frame_err_d = 1'b1;
          end else if (dec_bit_vld) begin
            sh_d = sh_shift;
            if (sh_shift == PREAMBLE) state_d = S_PRE2;
          end
        end
        S_PRE2: begin
          if (!dec_data_vld || timeout) begin
            state_d     = S_IDLE;
            frame_err_d = 1'b1;
          end else if (dec_bit_vld) begin
            sh_d = sh_shift;
            if (dec_bit == PREAMBLE[3'd7 - bit_cnt_q[2:0]]) begin
              if (bit_cnt_q == BC_W'(7)) begin
                state_d       = S_PAYLOAD;
                enter_payload = 1'b1;
              end else begin
                bit_cnt_d = bit_cnt_q + 1'b1;
              end
            end else if (sh_shift == PREAMBLE) begin
              bit_cnt_d = '0;
            end else begin
              state_d = S_HUNT;
            end
          end
        end
        S_PAYLOAD: begin
          if (!dec_data_vld || timeout) begin
            state_d     = S_IDLE;
            frame_err_d = 1'b1;
          end else if (dec_bit_vld) begin
            word_d = next_word;
            if (bit_cnt_q == LAST_BIT) begin
              bit_cnt_d     = '0;
              rx_word_d     = next_word;
              rx_word_vld_d = 1'b1;
              word_cnt_d    = word_cnt_q + 1'b1;
              if (word_cnt_q == LAST_WORD) begin
                frame_done_d = 1'b1;
                state_d      = S_DONE;
              end
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end
        end
        S_DONE:  if (!dec_data_vld) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end

    // Counters restart on every state change so they can never wrap across states.
    if (state_d != state_q) begin
      bit_cnt_d  = '0;
      word_cnt_d = '0;
      tmo_d      = '0;
    end
  end

  assign pdc_d = enter_payload;

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      sh_q          <= '0;
      bit_cnt_q     <= '0;
      word_cnt_q    <= '0;
      tmo_q         <= '0;
      word_q        <= '0;
      rx_word_q     <= '0;
      rx_word_vld_q <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_err_q   <= 1'b0;
      pdc_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      sh_q          <= sh_d;
      bit_cnt_q     <= bit_cnt_d;
      word_cnt_q    <= word_cnt_d;
      tmo_q         <= tmo_d;
      word_q        <= word_d;
      rx_word_q     <= rx_word_d;
      rx_word_vld_q <= rx_word_vld_d;
      frame_done_q  <= frame_done_d;
      frame_err_q   <= frame_err_d;
      pdc_q         <= pdc_d;
    end
  end

  assign rx_word               = rx_word_q;
  assign rx_word_vld           = rx_word_vld_q;
  assign frame_done            = frame_done_q;
  assign frame_err             = frame_err_q;
  assign preamble_double_check = pdc_q;
  assign state_dbg             = state_q;
  assign tdc_sum_vld_for_ten   = enable && dec_bit_vld && (state_q == S_PRE2) && (bit_cnt_q <= BC_W'(3));
  assign tdc_sum_vld_for_fif   = enable && dec_bit_vld && (state_q == S_PRE2) && (bit_cnt_q >= BC_W'(4));

endmodule

// File: doc/dmc_descramble_demux.md
Name: dmc_descramble_demux

Overview:
- Downstream stage of the DMC edge decoder. Consumes the decoder's serial decoded-bit stream and its bit strobe.
- Locates the 8-bit preamble and confirms it with a second consecutive preamble, then pulses preamble_double_check.
- Raises the TDC-sum sample strobes during the confirming preamble, used by the decoder's judge calibration.
- Descrambles the payload and demuxes it, MSB first, into parallel words. A frame is FRAME_WORDS words.

Parameters:
WORD_W, 8, payload word width in bits
FRAME_WORDS, 4, number of words per frame
PREAMBLE, 8'hAC, preamble pattern, MSB first (10101100)
LFSR_SEED, 7'h7F, descrambler seed, loaded at start of payload
TIMEOUT_CYC, 255, max clk_i cycles between bit strobes before abort (8-bit counter)

Ports:
clk_i  in  1  98MHz decode clock
reset_n  in  1  async active-low reset
enable  in  1  block enable; low forces IDLE
dec_bit  in  1  decoded bit from edge decoder
dec_bit_vld  in  1  one-cycle strobe, dec_bit valid
dec_data_vld  in  1  decoder data-valid level (session active)
rx_word  out  WORD_W  assembled payload word
rx_word_vld  out  1  one-cycle pulse, rx_word valid
frame_done  out  1  one-cycle pulse, last word of frame delivered
frame_err  out  1  one-cycle pulse, frame aborted
preamble_double_check  out  1  one-cycle pulse, second preamble matched
tdc_sum_vld_for_ten  out  1  combinational strobe, TDC sample for ten-judge sum
tdc_sum_vld_for_fif  out  1  combinational strobe, TDC sample for fif-judge sum
state_dbg  out  3  encoded state for debug bus

Behaviour:
- Interface: one clock, clk_i. Reset reset_n is asynchronous, active-low.
- Reset values:
  - All outputs 0. state=IDLE, state_dbg=0.
  - Shift register 0. LFSR = LFSR_SEED. All counters 0.
- States (state_dbg encoding): IDLE=0, HUNT=1, PRE2=2, PAYLOAD=3, DONE=4.
- enable low: synchronous return to IDLE next cycle; no pulses are emitted. Dominates all other transitions.
- IDLE:
  - Condition enable && dec_data_vld -> HUNT.
  - On entry to HUNT: clear shift register, bit_cnt, word_cnt and timeout counter.
- HUNT:
  - On each dec_bit_vld: sh <= {sh[6:0], dec_bit}.
  - If the new value equals PREAMBLE -> PRE2, bit_cnt=0.
- PRE2:
  - On each dec_bit_vld, compare dec_bit with PREAMBLE[7-bit_cnt]. The shift register keeps shifting.
  - Mismatch -> HUNT. If the updated shift register equals PREAMBLE, stay in PRE2 and reset bit_cnt=0 (a re-aligned first preamble).
  - Match with bit_cnt=7 -> PAYLOAD. Same edge: preamble_double_check=1 for one cycle, LFSR<=LFSR_SEED, bit_cnt=0, word_cnt=0.
  - TDC strobes, combinational and same cycle as dec_bit_vld:
    - tdc_sum_vld_for_ten = PRE2 && dec_bit_vld && bit_cnt<=3.
    - tdc_sum_vld_for_fif = PRE2 && dec_bit_vld && bit_cnt>=4.
    - Both strobes are gated by enable.
- PAYLOAD, on each dec_bit_vld:
  - ks = lfsr[6]^lfsr[5]; lfsr <= {lfsr[5:0], ks}.
  - Descrambled bit = dec_bit^ks, shifted MSB-first into the word register.
  - On the WORD_W-th bit: rx_word registered and rx_word_vld pulsed the following cycle (latency 1 clk after the last bit strobe). word_cnt increments.
  - On the FRAME_WORDS-th word: frame_done pulses in the same cycle as that rx_word_vld -> DONE.
- DONE: hold until dec_data_vld==0 -> IDLE. Bit strobes are ignored.
- Abort to IDLE with a one-cycle frame_err pulse, next cycle:
  - Timeout: in HUNT, PRE2 or PAYLOAD, TIMEOUT_CYC consecutive cycles with no dec_bit_vld. The counter clears on every strobe and saturates.
  - dec_data_vld falls in PRE2 or PAYLOAD. A partial word is discarded and no rx_word_vld is emitted.
  - dec_data_vld falling in HUNT -> IDLE with no frame_err.
- Simultaneous events:
  - Timeout and a strobe in the same cycle: the strobe wins and the counter clears.
  - enable low together with an abort: no frame_err.
- word_cnt and bit_cnt are never allowed to wrap; they clear on every state entry.
- Asserting reset_n mid-frame: immediate return to reset values; no pulses on release.

Optional Feature:
- Macro DMC_DESCRAMBLE_EN.
- Defined: payload bits are XORed with the LFSR keystream as above.
- Undefined: the LFSR logic is removed and payload bits pass raw (ks treated as 0). preamble_double_check and the TDC strobes are unchanged.

Test Plan:
- Raw mode (DMC_DESCRAMBLE_EN undefined): bits AC,AC,11,22,33,44 -> preamble_double_check x1; rx_word 11,22,33,44; frame_done with the 4th rx_word_vld; frame_err=0.
- DMC_DESCRAMBLE_EN defined, seed 7F: AC,AC then payload byte 0x13 -> first rx_word=0x11 (keystream 0x02).
- Strobe counts on AC,AC -> tdc_sum_vld_for_ten exactly 4 strobes, then tdc_sum_vld_for_fif exactly 4 strobes, all during the second AC; zero strobes during the first AC and during the payload.
- False preamble: AC,AD,AC,AC,payload -> no pulse after AD; preamble_double_check fires after the final AC; the words decode correctly.
- Abort: dec_data_vld drops after 3 payload bits -> frame_err pulse, no rx_word_vld, state_dbg=0. Separately, a 256-cycle strobe gap in PAYLOAD -> frame_err.
- enable low mid-PAYLOAD -> IDLE next cycle, frame_err=0. Async reset mid-PRE2 -> all outputs 0, no pulse on release.
